// File: rtl/fpu_stream_pkg.sv
// Shared types and constants for the byte-stream to FPU bridge.
package fpu_stream_pkg;

    typedef enum logic [1:0] {
        ST_RX    = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_TX    = 2'd3
    } state_t;

    localparam int unsigned CMD_BYTES = 9;
    localparam int unsigned RSP_BYTES = 5;

    // Bit positions inside the 8-bit FPU flag byte
    localparam int unsigned FLAG_INF         = 7;
    localparam int unsigned FLAG_SNAN        = 6;
    localparam int unsigned FLAG_QNAN        = 5;
    localparam int unsigned FLAG_INE         = 4;
    localparam int unsigned FLAG_OVERFLOW    = 3;
    localparam int unsigned FLAG_UNDERFLOW   = 2;
    localparam int unsigned FLAG_ZERO        = 1;
    localparam int unsigned FLAG_DIV_BY_ZERO = 0;

    // Synthetic response used when the FPU never answers
    localparam logic [31:0] TIMEOUT_NAN   = 32'h7FC0_0000;
    localparam logic [7:0]  TIMEOUT_FLAGS = 8'h20;

    // Response byte idx: 0..3 are result bytes LSB first, 4 is the flag byte
    function automatic logic [7:0] rsp_byte(input logic [31:0] result,
                                            input logic [7:0]  flags,
                                            input logic [2:0]  idx);
        case (idx)
            3'd0:    rsp_byte = result[7:0];
            3'd1:    rsp_byte = result[15:8];
            3'd2:    rsp_byte = result[23:16];
            3'd3:    rsp_byte = result[31:24];
            default: rsp_byte = flags;
        endcase
    endfunction

endpackage

// File: rtl/fpu_stream_bridge.sv
// Deserialises 9-byte commands into one FPU request, then serialises the
// 5-byte response; a single command is in flight at any time.
module fpu_stream_bridge
    import fpu_stream_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned TIMEOUT    = 255
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    input  logic [7:0]            in_data,
    output logic                  in_ready,
    output logic                  fpu_req,
    output logic [DATA_WIDTH-1:0] fpu_opa,
    output logic [DATA_WIDTH-1:0] fpu_opb,
    output logic [2:0]            fpu_op,
    output logic [1:0]            fpu_rmode,
    input  logic                  fpu_rsp_valid,
    input  logic [DATA_WIDTH-1:0] fpu_result,
    input  logic [7:0]            fpu_flags,
    output logic                  out_valid,
    output logic [7:0]            out_data,
    input  logic                  out_ready
);

    localparam int unsigned WCNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    state_t                  state;
    logic [3:0]              rx_cnt;
    logic [2:0]              tx_cnt;
    logic [WCNT_W-1:0]       wait_cnt;
    logic [7:0]              cmd_q [8];
    logic [DATA_WIDTH-1:0]   res_q;
    logic [7:0]              flags_q;

    // Control FSM with inline deserializer/serializer; every output is a flop
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ST_RX;
            rx_cnt    <= '0;
            tx_cnt    <= '0;
            wait_cnt  <= '0;
            in_ready  <= 1'b1;
            fpu_req   <= 1'b0;
            fpu_opa   <= '0;
            fpu_opb   <= '0;
            fpu_op    <= '0;
            fpu_rmode <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            res_q     <= '0;
            flags_q   <= '0;
            for (int i = 0; i < 8; i++) begin
                cmd_q[i] <= '0;
            end
        end else begin
            fpu_req <= 1'b0;
            case (state)
                ST_RX: begin
                    if (in_valid && in_ready) begin
                        if (rx_cnt == 4'(CMD_BYTES - 1)) begin
                            // Last byte carries op/rmode; launch straight from it
                            fpu_opb   <= {cmd_q[3], cmd_q[2], cmd_q[1], cmd_q[0]};
                            fpu_opa   <= {cmd_q[7], cmd_q[6], cmd_q[5], cmd_q[4]};
                            fpu_op    <= in_data[4:2];
                            fpu_rmode <= in_data[1:0];
                            fpu_req   <= 1'b1;
                            in_ready  <= 1'b0;
                            rx_cnt    <= '0;
                            state     <= ST_ISSUE;
                        end else begin
                            cmd_q[rx_cnt[2:0]] <= in_data;
                            rx_cnt             <= rx_cnt + 4'd1;
                        end
                    end
                end
                ST_ISSUE: begin
                    wait_cnt <= '0;
                    state    <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (fpu_rsp_valid) begin
                        res_q     <= fpu_result;
                        flags_q   <= fpu_flags;
                        out_data  <= rsp_byte(fpu_result, fpu_flags, 3'd0);
                        out_valid <= 1'b1;
                        tx_cnt    <= '0;
                        state     <= ST_TX;
                    end else if (wait_cnt == WCNT_W'(TIMEOUT - 1)) begin
                        res_q     <= TIMEOUT_NAN;
                        flags_q   <= TIMEOUT_FLAGS;
                        out_data  <= rsp_byte(TIMEOUT_NAN, TIMEOUT_FLAGS, 3'd0);
                        out_valid <= 1'b1;
                        tx_cnt    <= '0;
                        state     <= ST_TX;
                    end else begin
                        wait_cnt <= wait_cnt + WCNT_W'(1);
                    end
                end
                ST_TX: begin
                    if (out_ready) begin
                        if (tx_cnt == 3'(RSP_BYTES - 1)) begin
                            out_valid <= 1'b0;
                            out_data  <= '0;
                            tx_cnt    <= '0;
                            in_ready  <= 1'b1;
                            state     <= ST_RX;
                        end else begin
                            tx_cnt   <= tx_cnt + 3'd1;
                            out_data <= rsp_byte(res_q, flags_q, tx_cnt + 3'd1);
                        end
                    end
                end
                default: begin
                    state <= ST_RX;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fpu_stream_bridge.sv
// Self-checking bench for fpu_stream_bridge: vector table plus directed
// sequences for stalls, timeout, stray responses, reset and streaming input.
module tb_fpu_stream_bridge;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        fpu_req;
    logic [31:0] fpu_opa;
    logic [31:0] fpu_opb;
    logic [2:0]  fpu_op;
    logic [1:0]  fpu_rmode;
    logic        fpu_rsp_valid;
    logic [31:0] fpu_result;
    logic [7:0]  fpu_flags;
    logic        out_valid;
    logic [7:0]  out_data;
    logic        out_ready;

    fpu_stream_bridge #(.DATA_WIDTH(32), .TIMEOUT(255)) dut (
        .clk           (clk),
        .reset         (reset),
        .in_valid      (in_valid),
        .in_data       (in_data),
        .in_ready      (in_ready),
        .fpu_req       (fpu_req),
        .fpu_opa       (fpu_opa),
        .fpu_opb       (fpu_opb),
        .fpu_op        (fpu_op),
        .fpu_rmode     (fpu_rmode),
        .fpu_rsp_valid (fpu_rsp_valid),
        .fpu_result    (fpu_result),
        .fpu_flags     (fpu_flags),
        .out_valid     (out_valid),
        .out_data      (out_data),
        .out_ready     (out_ready)
    );

    typedef struct packed {
        logic [71:0] cmd;
        logic [31:0] res;
        logic [7:0]  flg;
        logic [31:0] opa;
        logic [31:0] opb;
        logic [2:0]  op;
        logic [1:0]  rmode;
    } vec_t;

    typedef struct packed {
        logic [31:0] opa;
        logic [31:0] opb;
        logic [2:0]  op;
        logic [1:0]  rmode;
    } req_t;

    vec_t        vecs [4];
    logic [7:0]  exp_q [$];
    req_t        req_q [$];

    int n_chk    = 0;
    int n_pass   = 0;
    int req_seen = 0;
    int out_cnt  = 0;

    int          rsp_cnt   = 0;
    int          fpu_delay = 1;
    bit          auto_fpu  = 1'b1;
    logic [31:0] cfg_res   = '0;
    logic [7:0]  cfg_flg   = '0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation still running, required finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, got, exp);
    endtask

    task automatic fail_now(input string name, input logic [31:0] got);
        n_chk++;
        $display("FAIL %s: got %h, expected none/within bound", name, got);
    endtask

    // One clock; inputs change 1 time unit after the edge; models the FPU
    task automatic tick();
        @(posedge clk);
        #1;
        fpu_rsp_valid = 1'b0;
        if (rsp_cnt > 0) begin
            rsp_cnt--;
            if (rsp_cnt == 0) begin
                fpu_rsp_valid = 1'b1;
                fpu_result    = cfg_res;
                fpu_flags     = cfg_flg;
            end
        end
        if (fpu_req && auto_fpu) rsp_cnt = fpu_delay;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int  n;
        bit  acc;
        n = 0;
        in_valid = 1'b1;
        in_data  = b;
        do begin
            acc = in_ready;
            tick();
            n++;
        end while (!acc && n < 2000);
        if (!acc) fail_now("in_accept_bound", 32'(n));
    endtask

    task automatic send_cmd(input logic [71:0] cmd, input bit keep);
        for (int i = 0; i < 9; i++) send_byte(cmd[8*i +: 8]);
        check("in_ready_drop", 32'(in_ready), 32'd0);
        if (!keep) in_valid = 1'b0;
    endtask

    task automatic expect_cmd(input vec_t v, input logic [31:0] res, input logic [7:0] flg);
        req_t r;
        r.opa   = v.opa;
        r.opb   = v.opb;
        r.op    = v.op;
        r.rmode = v.rmode;
        req_q.push_back(r);
        for (int i = 0; i < 4; i++) exp_q.push_back(res[8*i +: 8]);
        exp_q.push_back(flg);
    endtask

    task automatic wait_out(output int k);
        k = 0;
        while (!out_valid && k < 1000) begin
            tick();
            k++;
        end
        if (!out_valid) fail_now("wait_out_bound", 32'(k));
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || out_valid) && n < 2000) begin
            tick();
            n++;
        end
        if (n >= 2000) fail_now("drain_bound", 32'(exp_q.size()));
    endtask

    // Scoreboard: FPU issue and response bytes, sampled on the falling edge
    initial begin
        req_t        r;
        logic        prev_req;
        logic        hold_pend;
        logic [7:0]  hold_val;
        prev_req  = 1'b0;
        hold_pend = 1'b0;
        hold_val  = '0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                prev_req  = 1'b0;
                hold_pend = 1'b0;
            end else begin
                if (fpu_req) begin
                    req_seen++;
                    check("req_one_cycle", 32'(prev_req), 32'd0);
                    if (req_q.size() == 0) begin
                        fail_now("unexpected_fpu_req", fpu_opa);
                    end else begin
                        r = req_q.pop_front();
                        check("fpu_opa", fpu_opa, r.opa);
                        check("fpu_opb", fpu_opb, r.opb);
                        check("fpu_op", 32'(fpu_op), 32'(r.op));
                        check("fpu_rmode", 32'(fpu_rmode), 32'(r.rmode));
                    end
                end
                prev_req = fpu_req;
                if (hold_pend && out_valid) check("out_hold", 32'(out_data), 32'(hold_val));
                hold_pend = out_valid && !out_ready;
                hold_val  = out_data;
                if (out_valid && out_ready) begin
                    out_cnt++;
                    if (exp_q.size() == 0) fail_now("unexpected_out_byte", 32'(out_data));
                    else check("out_byte", 32'(out_data), 32'(exp_q.pop_front()));
                end
                if (in_valid && in_ready) check("rx_while_busy", 32'(out_valid), 32'd0);
            end
        end
    end

    initial begin
        int k;
        int base;
        int n;
        in_valid      = 1'b0;
        in_data       = '0;
        out_ready     = 1'b1;
        fpu_rsp_valid = 1'b0;
        fpu_result    = '0;
        fpu_flags     = '0;
        reset         = 1'b0;

        // byte8 layout {ignored[7:5], op[4:2], rmode[1:0]}; cmd = {byte8, opa, opb}
        vecs[0] = '{cmd: 72'h00_3F800000_40000000, res: 32'h40400000, flg: 8'h00,
                    opa: 32'h3F800000, opb: 32'h40000000, op: 3'd0, rmode: 2'd0};
        vecs[1] = '{cmd: 72'hE6_C0000000_3F800000, res: 32'hBF800000, flg: 8'h10,
                    opa: 32'hC0000000, opb: 32'h3F800000, op: 3'd1, rmode: 2'd2};
        vecs[2] = '{cmd: 72'h1F_12345678_9ABCDEF0, res: 32'hDEADBEEF, flg: 8'hFF,
                    opa: 32'h12345678, opb: 32'h9ABCDEF0, op: 3'd7, rmode: 2'd3};
        vecs[3] = '{cmd: 72'h0D_7F800000_00000000, res: 32'h7F800000, flg: 8'h81,
                    opa: 32'h7F800000, opb: 32'h00000000, op: 3'd3, rmode: 2'd1};

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_fpu_req", 32'(fpu_req), 32'd0);
        check("rst_fpu_opa", fpu_opa, 32'd0);
        check("rst_fpu_opb", fpu_opb, 32'd0);
        check("rst_fpu_op", 32'({fpu_op, fpu_rmode}), 32'd0);
        reset = 1'b1;
        tick();
        check("rst_in_ready", 32'(in_ready), 32'd1);

        // Vector table, response delay grows with index
        for (int i = 0; i < 4; i++) begin
            auto_fpu  = 1'b1;
            fpu_delay = i + 1;
            cfg_res   = vecs[i].res;
            cfg_flg   = vecs[i].flg;
            expect_cmd(vecs[i], vecs[i].res, vecs[i].flg);
            send_cmd(vecs[i].cmd, 1'b0);
            wait_out(k);
            check("latency", 32'(k), 32'(i + 2));
            drain();
            check("idle_in_ready", 32'(in_ready), 32'd1);
        end

        // Downstream stall on response byte 2
        fpu_delay = 1;
        cfg_res   = vecs[0].res;
        cfg_flg   = vecs[0].flg;
        expect_cmd(vecs[0], vecs[0].res, vecs[0].flg);
        send_cmd(vecs[0].cmd, 1'b0);
        base = out_cnt;
        n = 0;
        while (out_cnt < base + 2 && n < 100) begin
            tick();
            n++;
        end
        out_ready = 1'b0;
        check("stall_byte2", 32'({out_valid, out_data}), 32'h140);
        repeat (3) tick();
        check("stall_held", 32'({out_valid, out_data}), 32'h140);
        check("stall_in_ready", 32'(in_ready), 32'd0);
        out_ready = 1'b1;
        drain();
        check("stall_count", 32'(out_cnt - base), 32'd5);
        check("stall_in_ready_back", 32'(in_ready), 32'd1);

        // FPU never answers: synthetic NaN after the wait budget
        auto_fpu = 1'b0;
        expect_cmd(vecs[2], 32'h7FC00000, 8'h20);
        send_cmd(vecs[2].cmd, 1'b0);
        wait_out(k);
        check("timeout_latency", 32'(k), 32'd256);
        drain();

        // Stray responses in RX and ISSUE are ignored
        fpu_rsp_valid = 1'b1;
        fpu_result    = 32'h01234567;
        fpu_flags     = 8'h02;
        tick();
        tick();
        check("stray_rx_out_valid", 32'(out_valid), 32'd0);
        check("stray_rx_in_ready", 32'(in_ready), 32'd1);
        expect_cmd(vecs[3], 32'h3F800000, 8'h80);
        send_cmd(vecs[3].cmd, 1'b0);
        fpu_rsp_valid = 1'b1;
        fpu_result    = 32'hDEADBEEF;
        fpu_flags     = 8'h04;
        tick();
        tick();
        tick();
        check("stray_issue_ignored", 32'(out_valid), 32'd0);
        fpu_rsp_valid = 1'b1;
        fpu_result    = 32'h3F800000;
        fpu_flags     = 8'h80;
        tick();
        check("wait_rsp_taken", 32'(out_valid), 32'd1);
        drain();

        // Reset in the middle of a command discards the partial bytes
        auto_fpu  = 1'b1;
        fpu_delay = 2;
        for (int i = 0; i < 6; i++) send_byte(vecs[2].cmd[8*i +: 8]);
        in_valid = 1'b0;
        reset = 1'b0;
        #1;
        check("async_rst_opa", fpu_opa, 32'd0);
        check("async_rst_rmode", 32'({fpu_op, fpu_rmode}), 32'd0);
        tick();
        reset = 1'b1;
        tick();
        cfg_res = vecs[1].res;
        cfg_flg = vecs[1].flg;
        expect_cmd(vecs[1], vecs[1].res, vecs[1].flg);
        send_cmd(vecs[1].cmd, 1'b0);
        drain();

        // in_valid held high for two back-to-back commands
        fpu_delay = 1;
        cfg_res   = vecs[3].res;
        cfg_flg   = vecs[3].flg;
        base      = out_cnt;
        k         = req_seen;
        expect_cmd(vecs[0], vecs[3].res, vecs[3].flg);
        expect_cmd(vecs[2], vecs[3].res, vecs[3].flg);
        send_cmd(vecs[0].cmd, 1'b1);
        send_cmd(vecs[2].cmd, 1'b0);
        drain();
        check("stream_reqs", 32'(req_seen - k), 32'd2);
        check("stream_bytes", 32'(out_cnt - base), 32'd10);

        tick();
        check("exp_q_empty", 32'(exp_q.size()), 32'd0);
        check("req_q_empty", 32'(req_q.size()), 32'd0);
        check("total_reqs", 32'(req_seen), 32'd10);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
